part_dpram_param: RTL and testbench
===================================

PART_DPRAM_PARAM -- requirements
Module: part_dpram_param

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter AW, default 10: address width; depth SHALL be 2^AW words.
REQ-003 Parameter OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register stage, giving read latency 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 zeroes the whole array after reset; 0 skips clearing.
REQ-005 Port clk_a, input, 1 bit: the only clock; both ports are synchronous to it.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Ports address_a / address_b, input, AW bits: word address for port A / port B.
REQ-008 Ports data_a / data_b, input, WIDTH bits: write data for port A / port B.
REQ-009 Ports be_a / be_b, input, WIDTH/8 bits: byte-lane write enables; bit i enables bits [8i+7:8i].
REQ-010 Ports wren_a / wren_b, input, 1 bit: write request.
REQ-011 Ports rden_a / rden_b, input, 1 bit: read request.
REQ-012 Ports q_a / q_b, output, WIDTH bits: read data.
REQ-013 Ports valid_a / valid_b, output, 1 bit: one-cycle pulse marking q_x as the result of a read.
REQ-014 Port busy, output, 1 bit: high while the clear sequence runs; all requests are ignored while busy.
REQ-015 Port collision, output, 1 bit: registered pulse flagging a same-address dual write.

Function
REQ-016 Control FSM SHALL have exactly two states, CLEAR and RUN.
REQ-017 Reset SHALL enter CLEAR when CLEAR_ON_RESET=1 and RUN otherwise.
REQ-018 In CLEAR, a counter from 0 to 2^AW-1 SHALL write all-zero to one word per cycle, starting on the first cycle after reset deasserts.
REQ-019 The FSM SHALL move to RUN on the edge that writes word 2^AW-1; busy SHALL be 1 in CLEAR and 0 in RUN.
REQ-020 While busy=1, wren_x and rden_x SHALL be ignored, not queued; valid_x and collision SHALL stay 0.
REQ-021 In RUN, a write SHALL update only the byte lanes whose be_x bit is 1; a write with be_x=0 SHALL leave memory unchanged.
REQ-022 A write to port A and a write to port B at different addresses in the same cycle SHALL both commit on that edge.
REQ-023 For same-cycle writes to the same address:
- lanes enabled on A take data_a;
- lanes enabled only on B take data_b;
- collision SHALL pulse for one cycle after the edge, whether or not any lanes overlap.
REQ-024 A read SHALL return the array contents as they stood before any write committing on the same edge. This applies on the same port and across ports (read-old).
REQ-025 With OUT_REG=0, a read sampled at edge N SHALL drive q_x and valid_x=1 after edge N, and valid_x SHALL drop after edge N+1 unless another read is sampled.
REQ-026 With OUT_REG=1, q_x and valid_x SHALL appear one edge later than in REQ-025; back-to-back reads SHALL be fully pipelined at one per cycle per port.
REQ-027 When no read completes, q_x SHALL hold its last value and valid_x SHALL be 0.
REQ-028 Simultaneous rden_x and wren_x on one port SHALL perform both operations, with the read returning old data.
REQ-029 Ports A and B SHALL be independent; both reading the same address in the same cycle SHALL return identical data.

Reset
REQ-030 While reset=1, every output SHALL be 0 on each edge (q_a, q_b, valid_a, valid_b, collision), busy SHALL be 1 if CLEAR_ON_RESET=1, and all pipeline stages SHALL be flushed.
REQ-031 Reset asserted mid-clear or mid-read SHALL abort the operation and restart the clear from address 0; in-flight reads SHALL produce no valid pulse.
REQ-032 Array contents SHALL be preserved across reset when CLEAR_ON_RESET=0.

Verification
REQ-033 Clear: AW=4, reset released -> busy=1 for exactly 16 cycles, then all 16 words read 0; a write attempted while busy has no effect.
REQ-034 Byte lanes: write 0xAABBCCDD to address 5 with be=1111, then 0x11223344 with be=0101 -> read of address 5 returns 0xAA22CC44.
REQ-035 Collision: same cycle, A writes 0x000000FF be=0001 and B writes 0xFFFFFFFF be=1111 to address 7 -> read returns 0xFFFFFFFF and collision pulses once; repeat with A be=1111 data 0x12345678 -> read returns 0x12345678.
REQ-036 Read-old: address 3 holds 0x1; A writes 0x2 while B reads address 3 in the same cycle -> q_b=0x1 with valid_b, and the next read returns 0x2.
REQ-037 Latency: OUT_REG=1, rden_a held 4 cycles over addresses 0..3 -> valid_a high for 4 consecutive cycles starting 2 edges after the first request, with data in address order.
REQ-038 Reset mid-clear: reset asserted at clear count 9 of 16 -> busy stays high, the counter restarts at 0, and the total clear time after release is 16 cycles.

Source files
------------

// File: rtl/part_dpram_param_if.sv
// Bus bundle for the two-port RAM: per-port address/data/byte-enable/
// request inputs, read data with valid strobes, and the shared busy and
// collision status lines. Clock and reset stay outside the bundle.
interface part_dpram_param_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 10
);
   logic [AW-1:0]        address_a;
   logic [AW-1:0]        address_b;
   logic [WIDTH-1:0]     data_a;
   logic [WIDTH-1:0]     data_b;
   logic [WIDTH/8-1:0]   be_a;
   logic [WIDTH/8-1:0]   be_b;
   logic                 wren_a;
   logic                 wren_b;
   logic                 rden_a;
   logic                 rden_b;
   logic [WIDTH-1:0]     q_a;
   logic [WIDTH-1:0]     q_b;
   logic                 valid_a;
   logic                 valid_b;
   logic                 busy;
   logic                 collision;

   // Requester side: drives requests, observes results.
   modport master (
      output address_a, address_b, data_a, data_b, be_a, be_b,
             wren_a, wren_b, rden_a, rden_b,
      input  q_a, q_b, valid_a, valid_b, busy, collision
   );

   // RAM side: consumes requests, drives results.
   modport slave (
      input  address_a, address_b, data_a, data_b, be_a, be_b,
             wren_a, wren_b, rden_a, rden_b,
      output q_a, q_b, valid_a, valid_b, busy, collision
   );
endinterface

// File: rtl/part_dpram_param.sv
// True dual-port, byte-enabled RAM on a single clock. After reset an
// optional clear sequence zeroes every word (busy=1, requests dropped).
// Reads return pre-write (old) data; same-address dual writes give port A
// priority on its enabled lanes and raise a one-cycle collision pulse.
// Read latency is 1 cycle, or 2 with OUT_REG=1.
module part_dpram_param #(
   parameter int WIDTH          = 32,
   parameter int AW             = 10,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk_a,
   input  logic                reset,
   part_dpram_param_if.slave   bus
);

   localparam int NB    = WIDTH / 8;
   localparam int DEPTH = 1 << AW;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_busy;
   logic [AW-1:0]        r_clr_cnt;

   logic                 w_clr;
   logic                 w_run;
   logic                 w_wr_a;
   logic                 w_wr_b;
   logic                 w_rd_a;
   logic                 w_rd_b;

   logic [WIDTH-1:0]     r_mem [DEPTH];

   logic [WIDTH-1:0]     r_q1_a;
   logic [WIDTH-1:0]     r_q1_b;
   logic                 r_v1_a;
   logic                 r_v1_b;
   logic                 r_collision;

   // Control state register; reset picks the clear or run entry state.
   always_ff @(posedge clk_a) begin
      if (reset) begin
         r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and busy decode: leave CLEAR on the edge writing the last word.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_next_state = r_state;
      w_busy       = 1'b0;
      unique case (r_state)
         S_CLEAR: begin
            w_busy = 1'b1;
            if (&r_clr_cnt) begin
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            w_next_state = S_RUN;
         end
         default: begin
            w_next_state = S_RUN;
         end
      endcase
   end

   // Requests only act in RUN and outside reset; in CLEAR they are dropped.
   assign w_clr  = (r_state == S_CLEAR) && !reset;
   assign w_run  = (r_state == S_RUN)   && !reset;
   assign w_wr_a = w_run && bus.wren_a;
   assign w_wr_b = w_run && bus.wren_b;
   assign w_rd_a = w_run && bus.rden_a;
   assign w_rd_b = w_run && bus.rden_b;

   // Clear address counter; restarts from word 0 on every reset.
   always_ff @(posedge clk_a) begin
      if (reset) begin
         r_clr_cnt <= '0;
      end else if (w_clr) begin
         r_clr_cnt <= r_clr_cnt + AW'(1);
      end
   end

   // Array writes: clear sweep, else byte-lane writes with port A last so it
   // wins overlapping lanes at a shared address.
   always_ff @(posedge clk_a) begin
      // NOTE: the array has no reset branch; contents survive reset and are
      // only zeroed by the clear sweep, which keeps it mappable to block RAM.
      if (w_clr) begin
         r_mem[r_clr_cnt] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (w_wr_b && bus.be_b[i]) begin
               r_mem[bus.address_b][8*i +: 8] <= bus.data_b[8*i +: 8];
            end
         end
         // NOTE: both lane loops use non-blocking updates, so the later
         // port-A assignment overrides port B on shared lanes, and any read
         // in this edge still sees the pre-write word.
         for (int i = 0; i < NB; i++) begin
            if (w_wr_a && bus.be_a[i]) begin
               r_mem[bus.address_a][8*i +: 8] <= bus.data_a[8*i +: 8];
            end
         end
      end
   end

   // First read stage: capture the old word and a valid strobe per port.
   always_ff @(posedge clk_a) begin
      if (reset) begin
         r_q1_a <= '0;
         r_q1_b <= '0;
         r_v1_a <= 1'b0;
         r_v1_b <= 1'b0;
      end else begin
         r_v1_a <= w_rd_a;
         r_v1_b <= w_rd_b;
         if (w_rd_a) begin
            r_q1_a <= r_mem[bus.address_a];
         end
         if (w_rd_b) begin
            r_q1_b <= r_mem[bus.address_b];
         end
      end
   end

   // Same-address dual write flag, one cycle after the offending edge.
   always_ff @(posedge clk_a) begin
      if (reset) begin
         r_collision <= 1'b0;
      end else begin
         r_collision <= w_wr_a && w_wr_b && (bus.address_a == bus.address_b);
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [WIDTH-1:0] r_q2_a;
         logic [WIDTH-1:0] r_q2_b;
         logic             r_v2_a;
         logic             r_v2_b;

         // Optional output stage: forwards each valid read one cycle later.
         always_ff @(posedge clk_a) begin
            if (reset) begin
               r_q2_a <= '0;
               r_q2_b <= '0;
               r_v2_a <= 1'b0;
               r_v2_b <= 1'b0;
            end else begin
               r_v2_a <= r_v1_a;
               r_v2_b <= r_v1_b;
               if (r_v1_a) begin
                  r_q2_a <= r_q1_a;
               end
               if (r_v1_b) begin
                  r_q2_b <= r_q1_b;
               end
            end
         end

         assign bus.q_a     = r_q2_a;
         assign bus.q_b     = r_q2_b;
         assign bus.valid_a = r_v2_a;
         assign bus.valid_b = r_v2_b;
      end else begin : g_no_out_reg
         assign bus.q_a     = r_q1_a;
         assign bus.q_b     = r_q1_b;
         assign bus.valid_a = r_v1_a;
         assign bus.valid_b = r_v1_b;
      end
   endgenerate

   assign bus.busy      = w_busy;
   assign bus.collision = r_collision;

endmodule

// File: tb/tb_part_dpram_param.sv
// Directed bench for part_dpram_param. dut0: latency 1 with clear-on-reset;
// dut1: latency 2 with contents kept across reset. Both share clock/reset.
module tb_part_dpram_param;

   localparam int W  = 32;
   localparam int AW = 4;

   logic clk_a = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n;
   logic seen;

   part_dpram_param_if #(.WIDTH(W), .AW(AW)) if0 ();
   part_dpram_param_if #(.WIDTH(W), .AW(AW)) if1 ();

   part_dpram_param #(.WIDTH(W), .AW(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
      .clk_a (clk_a),
      .reset (reset),
      .bus   (if0)
   );

   part_dpram_param #(.WIDTH(W), .AW(AW), .OUT_REG(1), .CLEAR_ON_RESET(0)) u_dut1 (
      .clk_a (clk_a),
      .reset (reset),
      .bus   (if1)
   );

   always #5 clk_a = ~clk_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_a);
      #1;
   endtask

   task automatic idle0();
      if0.address_a = '0; if0.address_b = '0;
      if0.data_a = '0;    if0.data_b = '0;
      if0.be_a = '0;      if0.be_b = '0;
      if0.wren_a = 1'b0;  if0.wren_b = 1'b0;
      if0.rden_a = 1'b0;  if0.rden_b = 1'b0;
   endtask

   task automatic idle1();
      if1.address_a = '0; if1.address_b = '0;
      if1.data_a = '0;    if1.data_b = '0;
      if1.be_a = '0;      if1.be_b = '0;
      if1.wren_a = 1'b0;  if1.wren_b = 1'b0;
      if1.rden_a = 1'b0;  if1.rden_b = 1'b0;
   endtask

   task automatic wr_a0(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      if0.address_a = a; if0.data_a = d; if0.be_a = be; if0.wren_a = 1'b1;
      tick();
      idle0();
   endtask

   task automatic wr_a1(input logic [AW-1:0] a, input logic [31:0] d);
      if1.address_a = a; if1.data_a = d; if1.be_a = 4'hF; if1.wren_a = 1'b1;
      tick();
      idle1();
   endtask

   task automatic rd_a0(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
      if0.address_a = a; if0.rden_a = 1'b1;
      tick();
      idle0();
      check({tag, "_q_a"}, if0.q_a, exp);
      check({tag, "_valid_a"}, {31'd0, if0.valid_a}, 32'd1);
   endtask

   task automatic rd_b0(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
      if0.address_b = a; if0.rden_b = 1'b1;
      tick();
      idle0();
      check({tag, "_q_b"}, if0.q_b, exp);
      check({tag, "_valid_b"}, {31'd0, if0.valid_b}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle0();
      idle1();
      reset = 1'b1;
      repeat (3) tick();

      // Reset state of both instances.
      check("rst_q_a",       if0.q_a, 32'd0);
      check("rst_q_b",       if0.q_b, 32'd0);
      check("rst_valid_a",   {31'd0, if0.valid_a}, 32'd0);
      check("rst_valid_b",   {31'd0, if0.valid_b}, 32'd0);
      check("rst_collision", {31'd0, if0.collision}, 32'd0);
      check("rst_busy0",     {31'd0, if0.busy}, 32'd1);
      check("rst_busy1",     {31'd0, if1.busy}, 32'd0);
      check("rst_q_a1",      if1.q_a, 32'd0);

      // Release reset with writes and reads held on both ports during clear.
      reset = 1'b0;
      if0.address_a = 4'd2; if0.data_a = 32'hDEADBEEF; if0.be_a = 4'hF; if0.wren_a = 1'b1;
      if0.address_b = 4'd2; if0.data_b = 32'hCAFEF00D; if0.be_b = 4'hF; if0.wren_b = 1'b1;
      if0.rden_a = 1'b1; if0.rden_b = 1'b1;
      n = 0;
      seen = 1'b0;
      while (if0.busy && n < 40) begin
         tick();
         n++;
         if (if0.valid_a || if0.valid_b || if0.collision) seen = 1'b1;
      end
      idle0();
      check("clear_cycles", n, 32'd16);
      check("busy_flags_quiet", {31'd0, seen}, 32'd0);

      // Every word reads zero after the sweep.
      for (int i = 0; i < 16; i++) begin
         rd_a0(AW'(i), 32'd0, "clear_word");
      end

      // Byte-lane writes.
      wr_a0(4'd5, 32'hAABBCCDD, 4'hF);
      wr_a0(4'd5, 32'h11223344, 4'h5);
      rd_a0(4'd5, 32'hAA22CC44, "byte_lanes");
      tick();
      check("valid_drop", {31'd0, if0.valid_a}, 32'd0);
      check("q_hold", if0.q_a, 32'hAA22CC44);

      // A write with no lanes enabled changes nothing.
      wr_a0(4'd5, 32'hFFFFFFFF, 4'h0);
      rd_b0(4'd5, 32'hAA22CC44, "be_zero");

      // Dual write at different addresses, then cross-read.
      if0.address_a = 4'd8; if0.data_a = 32'h01010101; if0.be_a = 4'hF; if0.wren_a = 1'b1;
      if0.address_b = 4'd9; if0.data_b = 32'h02020202; if0.be_b = 4'hF; if0.wren_b = 1'b1;
      tick();
      idle0();
      check("diff_addr_no_coll", {31'd0, if0.collision}, 32'd0);
      if0.address_a = 4'd9; if0.rden_a = 1'b1;
      if0.address_b = 4'd8; if0.rden_b = 1'b1;
      tick();
      idle0();
      check("diff_addr_q_a", if0.q_a, 32'h02020202);
      check("diff_addr_q_b", if0.q_b, 32'h01010101);

      // Same-address collision, disjoint A lane.
      if0.address_a = 4'd7; if0.data_a = 32'h000000FF; if0.be_a = 4'h1; if0.wren_a = 1'b1;
      if0.address_b = 4'd7; if0.data_b = 32'hFFFFFFFF; if0.be_b = 4'hF; if0.wren_b = 1'b1;
      tick();
      idle0();
      check("coll1_pulse", {31'd0, if0.collision}, 32'd1);
      tick();
      check("coll1_drop", {31'd0, if0.collision}, 32'd0);
      rd_a0(4'd7, 32'hFFFFFFFF, "coll1_data");

      // Same-address collision, A covers all lanes.
      if0.address_a = 4'd7; if0.data_a = 32'h12345678; if0.be_a = 4'hF; if0.wren_a = 1'b1;
      if0.address_b = 4'd7; if0.data_b = 32'hFFFFFFFF; if0.be_b = 4'hF; if0.wren_b = 1'b1;
      tick();
      idle0();
      check("coll2_pulse", {31'd0, if0.collision}, 32'd1);
      rd_a0(4'd7, 32'h12345678, "coll2_data");

      // Read-old across ports.
      wr_a0(4'd3, 32'h00000001, 4'hF);
      if0.address_a = 4'd3; if0.data_a = 32'h00000002; if0.be_a = 4'hF; if0.wren_a = 1'b1;
      if0.address_b = 4'd3; if0.rden_b = 1'b1;
      tick();
      idle0();
      check("rdold_q_b", if0.q_b, 32'h00000001);
      check("rdold_valid_b", {31'd0, if0.valid_b}, 32'd1);
      rd_a0(4'd3, 32'h00000002, "rdold_next");

      // Read-old on the same port.
      if0.address_a = 4'd3; if0.data_a = 32'h00000003; if0.be_a = 4'hF;
      if0.wren_a = 1'b1; if0.rden_a = 1'b1;
      tick();
      idle0();
      check("sameport_old", if0.q_a, 32'h00000002);
      rd_b0(4'd3, 32'h00000003, "sameport_new");

      // Both ports reading one address together.
      if0.address_a = 4'd5; if0.rden_a = 1'b1;
      if0.address_b = 4'd5; if0.rden_b = 1'b1;
      tick();
      idle0();
      check("dual_rd_q_a", if0.q_a, 32'hAA22CC44);
      check("dual_rd_q_b", if0.q_b, 32'hAA22CC44);

      // Two-stage latency on dut1: preload, then stream four reads.
      for (int i = 0; i < 4; i++) begin
         wr_a1(AW'(i), 32'hA0000000 + 32'(i));
      end
      if1.address_a = 4'd0; if1.rden_a = 1'b1;
      tick();
      check("lat_e1_valid", {31'd0, if1.valid_a}, 32'd0);
      if1.address_a = 4'd1;
      tick();
      check("lat_e2_valid", {31'd0, if1.valid_a}, 32'd1);
      check("lat_e2_q", if1.q_a, 32'hA0000000);
      if1.address_a = 4'd2;
      tick();
      check("lat_e3_valid", {31'd0, if1.valid_a}, 32'd1);
      check("lat_e3_q", if1.q_a, 32'hA0000001);
      if1.address_a = 4'd3;
      tick();
      check("lat_e4_valid", {31'd0, if1.valid_a}, 32'd1);
      check("lat_e4_q", if1.q_a, 32'hA0000002);
      idle1();
      tick();
      check("lat_e5_valid", {31'd0, if1.valid_a}, 32'd1);
      check("lat_e5_q", if1.q_a, 32'hA0000003);
      tick();
      check("lat_e6_valid", {31'd0, if1.valid_a}, 32'd0);

      // Reset during in-flight reads: no valid pulse may escape.
      if1.address_a = 4'd1; if1.rden_a = 1'b1;
      tick();
      idle1();
      reset = 1'b1;
      if0.address_a = 4'd5; if0.rden_a = 1'b1;
      tick();
      idle0();
      check("rst_rd_valid0", {31'd0, if0.valid_a}, 32'd0);
      check("rst_rd_q0", if0.q_a, 32'd0);
      check("rst_rd_valid1", {31'd0, if1.valid_a}, 32'd0);
      check("rst_rd_busy0", {31'd0, if0.busy}, 32'd1);
      tick();

      // Reset mid-clear at count 9, then a full 16-cycle sweep.
      reset = 1'b0;
      repeat (9) tick();
      check("midclr_busy", {31'd0, if0.busy}, 32'd1);
      reset = 1'b1;
      tick();
      check("midclr_rst_busy", {31'd0, if0.busy}, 32'd1);
      reset = 1'b0;
      n = 0;
      while (if0.busy && n < 40) begin
         tick();
         n++;
      end
      check("midclr_cycles", n, 32'd16);
      check("noclr_busy1", {31'd0, if1.busy}, 32'd0);
      rd_a0(4'd5, 32'd0, "reclear_word5");
      rd_a0(4'd9, 32'd0, "reclear_word9");

      // dut1 keeps its contents across reset.
      if1.address_a = 4'd2; if1.rden_a = 1'b1;
      tick();
      idle1();
      tick();
      check("keep_q", if1.q_a, 32'hA0000002);
      check("keep_valid", {31'd0, if1.valid_a}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
